// File: rtl/mux_pipe_nx1.sv
// Pipelined N:1 channel multiplexer built as a registered binary 2:1 tree.
// Stage k resolves select bit k (LSB first), so LEVELS = SEL_W register
// stages. A valid/ready handshake with whole-pipe stall provides
// backpressure. An optional scan counter can supply the index instead of sel.
module mux_pipe_nx1 #(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 16,
  parameter int SEL_W     = $clog2(NUM_CH),
  parameter int SCAN_LAST = NUM_CH - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     scan_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int LEVELS = SEL_W;
  localparam int NLEAF  = 1 << SEL_W;

  logic                    advance;
  logic                    launch;
  logic                    launch_err;
  logic [SEL_W-1:0]        launch_idx;
  logic [SEL_W-1:0]        scan_q;
  logic [SEL_W-1:0]        scan_d;
  logic [NLEAF*DATA_W-1:0] leaves;

  // The whole pipe moves together; bubbles are kept, never collapsed.
  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance;
  assign launch     = in_valid && advance;
  assign launch_idx = scan_en ? scan_q : sel;
  assign launch_err = (32'(launch_idx) >= 32'(NUM_CH));

  // Pad the channel set to a power of two; padding leaves read as zero, so an
  // out-of-range index naturally produces zero data at the tree output.
  always_comb begin
    leaves = '0;
    leaves[NUM_CH*DATA_W-1:0] = data_in;
  end

  // Scan counter steps only on scan-mode launches and wraps after SCAN_LAST.
  always_comb begin
    scan_d = scan_q;
    if (launch && scan_en) begin
      scan_d = (32'(scan_q) == 32'(SCAN_LAST)) ? '0 : scan_q + 1'b1;
    end
  end

  // Scan counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_d;
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NC = NLEAF >> (k + 1);

    logic [2*NC*DATA_W-1:0] src;
    logic [SEL_W-1:0]       src_idx;
    logic                   src_err;
    logic                   src_vld;
    logic [NC*DATA_W-1:0]   dat_d;
    logic [NC*DATA_W-1:0]   dat_q;
    logic [SEL_W-1:0]       idx_q;
    logic                   err_q;
    logic                   vld_q;

    if (k == 0) begin : g_first
      assign src     = leaves;
      assign src_idx = launch_idx;
      assign src_err = launch_err;
      assign src_vld = launch;
    end else begin : g_next
      assign src     = g_lvl[k-1].dat_q;
      assign src_idx = g_lvl[k-1].idx_q;
      assign src_err = g_lvl[k-1].err_q;
      assign src_vld = g_lvl[k-1].vld_q;
    end

    // Halve the candidate set using index bit k.
    always_comb begin
      dat_d = '0;
      for (int j = 0; j < NC; j++) begin
        dat_d[j*DATA_W +: DATA_W] = src_idx[k] ? src[(2*j+1)*DATA_W +: DATA_W]
                                               : src[(2*j)*DATA_W +: DATA_W];
      end
    end

    // Stage register: shifts on advance, otherwise holds (bubbles included).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dat_q <= '0;
        idx_q <= '0;
        err_q <= 1'b0;
        vld_q <= 1'b0;
      end else if (advance) begin
        dat_q <= dat_d;
        idx_q <= src_idx;
        err_q <= src_err;
        vld_q <= src_vld;
      end
    end
  end

  assign out_data  = g_lvl[LEVELS-1].dat_q;
  assign out_ch    = g_lvl[LEVELS-1].idx_q;
  assign out_err   = g_lvl[LEVELS-1].err_q;
  assign out_valid = g_lvl[LEVELS-1].vld_q;

endmodule

// File: tb/tb_mux_pipe_nx1.sv
// Bench for mux_pipe_nx1: instance 0 is 16 channels with SCAN_LAST=5,
// instance 1 is 10 channels (non power of two). A queue-based reference
// model predicts every output item from the launch-time inputs.
module tb_mux_pipe_nx1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] din       [2];
  logic [3:0]   sel       [2];
  logic         scan_en   [2];
  logic         in_valid  [2];
  logic         out_ready [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         out_err   [2];
  logic [7:0]   out_data  [2];
  logic [3:0]   out_ch    [2];

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;

  // reference model state
  logic [7:0] q_data [2][256];
  logic [3:0] q_ch   [2][256];
  logic       q_err  [2][256];
  int         wr [2];
  int         rd [2];
  int         scnt [2];
  logic       hold [2];
  logic [7:0] h_data [2];
  logic [3:0] h_ch [2];
  logic       h_err [2];

  // observation log
  logic [7:0] lg_data [2][1024];
  logic [3:0] lg_ch   [2][1024];
  logic       lg_err  [2][1024];
  int         lg_cyc  [2][1024];
  int         hs [2];
  int         first_v [2];
  int         last_v [2];

  always #5 clk = ~clk;

  mux_pipe_nx1 #(.DATA_W(8), .NUM_CH(16), .SCAN_LAST(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]), .sel(sel[0]),
    .scan_en(scan_en[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_ch(out_ch[0]), .out_err(out_err[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  mux_pipe_nx1 #(.DATA_W(8), .NUM_CH(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(din[1][79:0]), .sel(sel[1]),
    .scan_en(scan_en[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_ch(out_ch[1]), .out_err(out_err[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  function automatic int nch(input int d);
    return (d == 0) ? 16 : 10;
  endfunction

  function automatic int slast(input int d);
    return (d == 0) ? 5 : 9;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      wr[d] = 0; rd[d] = 0; scnt[d] = 0; hold[d] = 1'b0;
    end
  endtask

  // One clock: evaluate at the falling edge, then return 1 time unit after the rising edge.
  task automatic cyc();
    int idx;
    logic e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("in_ready_d%0d", d), in_ready[d], !out_valid[d] || out_ready[d]);
      if (hold[d]) begin
        check($sformatf("hold_valid_d%0d", d), out_valid[d], 1'b1);
        check($sformatf("hold_data_d%0d", d), out_data[d], h_data[d]);
        check($sformatf("hold_ch_d%0d", d), out_ch[d], h_ch[d]);
        check($sformatf("hold_err_d%0d", d), out_err[d], h_err[d]);
      end
      if (out_valid[d] && first_v[d] < 0) first_v[d] = ncyc;
      if (out_valid[d] && out_ready[d]) begin
        check($sformatf("item_expected_d%0d", d), wr[d] != rd[d], 1'b1);
        if (wr[d] != rd[d]) begin
          check($sformatf("data_d%0d", d), out_data[d], q_data[d][rd[d] % 256]);
          check($sformatf("ch_d%0d", d), out_ch[d], q_ch[d][rd[d] % 256]);
          check($sformatf("err_d%0d", d), out_err[d], q_err[d][rd[d] % 256]);
          rd[d]++;
        end
        lg_data[d][hs[d] % 1024] = out_data[d];
        lg_ch[d][hs[d] % 1024]   = out_ch[d];
        lg_err[d][hs[d] % 1024]  = out_err[d];
        lg_cyc[d][hs[d] % 1024]  = ncyc;
        hs[d]++;
        last_v[d] = ncyc;
      end
      hold[d]   = out_valid[d] && !out_ready[d];
      h_data[d] = out_data[d];
      h_ch[d]   = out_ch[d];
      h_err[d]  = out_err[d];
      if (in_valid[d] && in_ready[d]) begin
        idx = scan_en[d] ? scnt[d] : int'(sel[d]);
        e = (idx >= nch(d));
        q_data[d][wr[d] % 256] = e ? 8'h00 : din[d][idx*8 +: 8];
        q_ch[d][wr[d] % 256]   = 4'(idx);
        q_err[d][wr[d] % 256]  = e;
        wr[d]++;
        if (scan_en[d]) scnt[d] = (scnt[d] == slast(d)) ? 0 : scnt[d] + 1;
      end
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) din[0][i*8 +: 8] = 8'(8'hA0 + i);
    din[1] = '0;
    for (int i = 0; i < 10; i++) din[1][i*8 +: 8] = 8'(8'hB0 + i);
  endtask

  initial begin
    int t0;
    int b;
    int n;
    int exp_sc [8];
    exp_sc = '{0, 1, 2, 3, 4, 5, 0, 1};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      din[d] = '0; sel[d] = '0; scan_en[d] = 1'b0; in_valid[d] = 1'b0;
      out_ready[d] = 1'b1; hs[d] = 0; first_v[d] = -1; last_v[d] = -1;
    end
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid_d%0d", d), out_valid[d], 1'b0);
      check($sformatf("rst_data_d%0d", d), out_data[d], 8'h00);
      check($sformatf("rst_ch_d%0d", d), out_ch[d], 4'h0);
      check($sformatf("rst_err_d%0d", d), out_err[d], 1'b0);
      check($sformatf("rst_in_ready_d%0d", d), in_ready[d], 1'b1);
    end

    // directed sweep sel=0..15 back-to-back
    set_ramp();
    first_v[0] = -1;
    b = hs[0];
    t0 = ncyc;
    for (int i = 0; i < 16; i++) begin
      sel[0] = 4'(i); in_valid[0] = 1'b1;
      cyc();
    end
    in_valid[0] = 1'b0;
    repeat (8) cyc();
    check("sweep_latency", first_v[0] - t0, 4);
    check("sweep_span", last_v[0] - first_v[0], 15);
    check("sweep_count", hs[0] - b, 16);
    check("sweep_first", lg_data[0][b % 1024], 8'hA0);
    check("sweep_last", lg_data[0][(b + 15) % 1024], 8'hAF);

    // backpressure: 3, 7, 9 then stall five cycles
    b = hs[0];
    out_ready[0] = 1'b0;
    foreach (exp_sc[i]) if (i < 3) begin
      sel[0] = (i == 0) ? 4'd3 : (i == 1) ? 4'd7 : 4'd9;
      in_valid[0] = 1'b1;
      cyc();
    end
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 10) begin
      cyc();
      n++;
    end
    check("bp_wait_in_bound", n < 10, 1'b1);
    repeat (5) begin
      check("bp_in_ready", in_ready[0], 1'b0);
      check("bp_data", out_data[0], 8'hA3);
      cyc();
    end
    out_ready[0] = 1'b1;
    repeat (6) cyc();
    check("bp_count", hs[0] - b, 3);
    check("bp_second", lg_data[0][(b + 1) % 1024], 8'hA7);
    check("bp_third", lg_data[0][(b + 2) % 1024], 8'hA9);

    // scan mode with bubbles between launches
    b = hs[0];
    scan_en[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel[0] = 4'($urandom_range(0, 15));
      in_valid[0] = 1'b1;
      cyc();
      in_valid[0] = 1'b0;
      cyc();
    end
    scan_en[0] = 1'b0;
    repeat (6) cyc();
    check("scan_count", hs[0] - b, 8);
    for (int i = 0; i < 8; i++) check($sformatf("scan_ch%0d", i), lg_ch[0][(b + i) % 1024], exp_sc[i]);

    // bubble is preserved, not collapsed
    b = hs[0];
    t0 = ncyc;
    sel[0] = 4'd1; in_valid[0] = 1'b1; cyc();
    in_valid[0] = 1'b0; cyc();
    sel[0] = 4'd2; in_valid[0] = 1'b1; cyc();
    in_valid[0] = 1'b0;
    repeat (6) cyc();
    check("bubble_latency", lg_cyc[0][b % 1024] - t0, 4);
    check("bubble_gap", lg_cyc[0][(b + 1) % 1024] - lg_cyc[0][b % 1024], 2);

    // non power of two: in-range and out-of-range select
    b = hs[1];
    sel[1] = 4'd9;  in_valid[1] = 1'b1; cyc();
    sel[1] = 4'd12; cyc();
    in_valid[1] = 1'b0;
    repeat (6) cyc();
    check("np2_data9", lg_data[1][b % 1024], 8'hB9);
    check("np2_err9", lg_err[1][b % 1024], 1'b0);
    check("np2_data12", lg_data[1][(b + 1) % 1024], 8'h00);
    check("np2_ch12", lg_ch[1][(b + 1) % 1024], 4'd12);
    check("np2_err12", lg_err[1][(b + 1) % 1024], 1'b1);

    // data_in sampled only at launch
    b = hs[0];
    din[0][5*8 +: 8] = 8'h55;
    sel[0] = 4'd5; in_valid[0] = 1'b1; cyc();
    in_valid[0] = 1'b0;
    din[0][5*8 +: 8] = 8'hAA;
    repeat (6) cyc();
    check("sample_at_launch", lg_data[0][b % 1024], 8'h55);

    // asynchronous reset mid-stream
    scan_en[0] = 1'b1;
    in_valid[0] = 1'b1;
    repeat (6) cyc();
    in_valid[0] = 1'b0;
    scan_en[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_a", out_valid[0], 1'b0);
    check("arst_valid_b", out_valid[1], 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    b = hs[0];
    repeat (8) cyc();
    check("arst_no_stale", hs[0] - b, 0);
    check("arst_in_ready", in_ready[0], 1'b1);
    scan_en[0] = 1'b1; in_valid[0] = 1'b1; cyc();
    in_valid[0] = 1'b0; scan_en[0] = 1'b0;
    repeat (6) cyc();
    check("arst_scan_restart", lg_ch[0][b % 1024], 4'd0);

    // randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = ($urandom_range(0, 3) != 0);
        out_ready[d] = ($urandom_range(0, 2) != 0);
        sel[d]       = 4'($urandom_range(0, 15));
        scan_en[d]   = ($urandom_range(0, 3) == 0);
        din[d]       = {$urandom, $urandom, $urandom, $urandom};
      end
      cyc();
    end
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    end
    repeat (10) cyc();
    check("drain_a", wr[0] - rd[0], 0);
    check("drain_b", wr[1] - rd[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
